// File: rtl/piso_serializer_if.sv
// piso_serializer_if: parallel word handshake in, MSB-first serial stream out
interface piso_serializer_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic sout;
  logic sout_valid;
  logic frame_start;
  logic done;
  logic busy;
  modport master (output din, din_valid, input din_ready, sout, sout_valid, frame_start, done, busy);
  modport slave (input din, din_valid, output din_ready, sout, sout_valid, frame_start, done, busy);
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: holding register + shifter, emits words MSB first with no gap between words
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic rst,
  piso_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d, shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic hold_full_q, hold_full_d, ready_q, accept, load, shifting;
  always_comb begin
    accept = bus.din_valid & ready_q;
    load = hold_full_q & (state_q == IDLE || cnt_q == '0);
    state_d = load ? SHIFT : (cnt_q == '0 ? IDLE : state_q);
    shreg_d = load ? hold_q : (state_q == SHIFT ? {shreg_q[WIDTH-2:0], 1'b0} : shreg_q);
    cnt_d = load ? LAST : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    hold_d = accept ? bus.din : hold_q;
    hold_full_d = accept | (hold_full_q & ~load);
  end
  // ready tracks the next hold_full so it drops at the accept edge and rises at the load edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      hold_q <= '0;
      hold_full_q <= 1'b0;
      cnt_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      hold_q <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q <= cnt_d;
      ready_q <= ~hold_full_d;
    end
  end
  assign shifting = state_q == SHIFT;
  assign bus.din_ready = ready_q;
  assign bus.sout = shifting & shreg_q[WIDTH-1];
  assign bus.sout_valid = shifting;
  assign bus.frame_start = shifting && cnt_q == LAST;
  assign bus.done = shifting && cnt_q == '0;
  assign bus.busy = shifting | hold_full_q;
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter: WIDTH, default 4, parallel word width in bits; WIDTH SHALL be >= 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled only on rising clk edges.
REQ-004 din  input  WIDTH  parallel word to serialize.
REQ-005 din_valid  input  1  din holds a word for transfer.
REQ-006 din_ready  output  1  block can accept a word this cycle.
REQ-007 sout  output  1  serial bit stream, MSB first; feeds the downstream shift register's serial input.
REQ-008 sout_valid  output  1  sout carries a data bit this cycle.
REQ-009 frame_start  output  1  one-cycle pulse while a word's MSB is on sout.
REQ-010 done  output  1  one-cycle pulse while a word's LSB is on sout.
REQ-011 busy  output  1  high when the shifter is active or the holding register is full.

Function
REQ-012 Handshake: transfer SHALL occur at a rising edge where din_valid=1 and din_ready=1; din is ignored at every other edge.
REQ-013 Storage: one WIDTH-bit holding register (hold, flag hold_full) plus one WIDTH-bit shifter (shreg) with a bit counter of ceil(log2(WIDTH)) bits.
REQ-014 din_ready SHALL equal !hold_full, registered, with no combinational path from din_valid.
REQ-015 Accepted word SHALL be written into hold; hold_full sets at that edge.
REQ-016 State machine: IDLE (shifter empty) and SHIFT (shifter driving bits).
REQ-017 IDLE -> SHIFT at an edge where hold_full=1: shreg <= hold, counter <= WIDTH-1, hold_full clears.
REQ-018 In SHIFT, each edge: shreg <= {shreg[WIDTH-2:0], 1'b0} (left shift, zero fill); counter decrements.
REQ-019 On the edge ending the LSB cycle (counter=0): if hold_full=1, reload per REQ-017 and stay in SHIFT (no gap bit); otherwise go to IDLE.
REQ-020 sout SHALL equal shreg[WIDTH-1] in SHIFT and 0 in IDLE; sout_valid=1 exactly in SHIFT.
REQ-021 Latency: word accepted at edge N with shifter idle -> MSB on sout in the cycle after edge N+1; WIDTH consecutive bits follow.
REQ-022 Throughput: with din_valid held high, output SHALL be continuous (sout_valid never low between words).
REQ-023 frame_start=1 iff SHIFT and counter=WIDTH-1; done=1 iff SHIFT and counter=0.
REQ-024 Simultaneous accept and hold->shreg transfer cannot occur (din_ready=0 while hold_full); din_ready rises the cycle after hold empties.
REQ-025 All outputs SHALL be driven from registers or decodes of registered state only.

Reset
REQ-026 While rst=0 at an edge: state <= IDLE, shreg <= 0, hold <= 0, hold_full <= 0, counter <= 0.
REQ-027 During and after reset edge: sout=0, sout_valid=0, frame_start=0, done=0, busy=0; din_ready=0 while rst=0, 1 in the first cycle after rst returns high.
REQ-028 Reset mid-word SHALL discard both the in-flight and the held word; no partial bits emitted afterwards.

Verification (WIDTH=4 unless stated)
REQ-029 Reset: rst=0 for 2 edges, din_valid=1 -> no handshake; sout=0, sout_valid=0, busy=0, din_ready=0; after release din_ready=1.
REQ-030 Single word: accept 4'b1011 at edge N -> sout 1,0,1,1 in cycles after N+1..N+4; frame_start on first, done on fourth; sout_valid=0 after.
REQ-031 Back-to-back: 4'b1011 then 4'b0110 with din_valid held -> 8 contiguous bits 1,0,1,1,0,1,1,0, sout_valid continuously 1, two done pulses 4 cycles apart.
REQ-032 Backpressure: third word offered while hold_full=1 -> din_ready=0, changes on din ignored until ready returns; word then emitted intact.
REQ-033 Reset mid-word: rst=0 after 2 bits of 4'b1011 with 4'b0110 held -> next cycle all outputs 0; then 4'b1000 emits 1,0,0,0 only.
REQ-034 WIDTH=8: 8'hA5 -> sout 1,0,1,0,0,1,0,1; frame_start and done each pulse once, 7 cycles apart.
